// File: rtl/fft_window_mc_if.sv
// One AXI-Stream style beat channel (data, valid, last, ready) between the window stage and its neighbours.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface fft_window_mc_if #(
  parameter int W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_window_mc.sv
// Multiplies CH packed channels by one Q1.FRAC window coefficient per beat, rounds half up and saturates.
// Three stages with 3 clk latency; all stages stall together while an output beat is held (tready_s = en).
module fft_window_mc #(
  parameter int    DW       = 16,
  parameter int    CW       = 16,
  parameter int    FRAC     = 15,
  parameter int    CH       = 2,
  parameter int    N_LOG2   = 10,
  parameter string MEM_FILE = "window.mem"
) (
  input  logic              clk,
  input  logic              reset_n,
  fft_window_mc_if.slave    s,
  fft_window_mc_if.master   m,
  input  logic [N_LOG2:0]   cfg_len,
  input  logic              cfg_bypass,
  input  logic              coef_we,
  input  logic [N_LOG2-1:0] coef_addr,
  input  logic [CW-1:0]     coef_wdata,
  output logic              short_frame,
  input  logic              short_clr
);
  localparam int LW  = N_LOG2 + 1;
  localparam int CWE = CW + 1;
  localparam int PW  = DW + CW + 1;
  localparam logic [LW-1:0]         LEN_MAX = LW'(1) << N_LOG2;
  localparam logic signed [CWE-1:0] UNITY   = CWE'(1) << FRAC;
  localparam logic signed [PW-1:0]  RND     = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0]  SMAX    = (PW'(1) << (DW - 1)) - PW'(1);
  localparam logic signed [PW-1:0]  SMIN    = -(PW'(1) << (DW - 1));

  if (FRAC < 1 || FRAC >= CW) begin : g_bad_frac
    $error("fft_window_mc: FRAC must lie in 1..CW-1 for coefficient image %s", MEM_FILE);
  end

  logic signed [CW-1:0] coef_mem [2**N_LOG2];
  logic signed [CW-1:0] coef_rd;

  logic [N_LOG2-1:0] idx;
  logic [LW-1:0]     len_q, len_cur, cfg_len_n;
  logic              byp_q, byp_cur, rdy_ok, en, hs, at_end;

  logic                     s1_vld, s1_last, s1_byp;
  logic signed [DW-1:0]     s1_smp [CH];
  logic signed [CWE-1:0]    coef_eff;
  logic signed [PW-1:0]     prod   [CH];
  logic                     s2_vld, s2_last;
  logic signed [PW-1:0]     s2_prod [CH];
  logic signed [PW-1:0]     rnd    [CH];
  logic [CH*DW-1:0]         o_dat;

  // Unity does not fit in CW signed bits, so the coefficient path carries one extra bit.
  always_comb begin
    cfg_len_n = (cfg_len == '0) ? LEN_MAX : cfg_len;
    len_cur   = (idx == '0) ? cfg_len_n : len_q;
    byp_cur   = (idx == '0) ? cfg_bypass : byp_q;
    at_end    = ({1'b0, idx} == (len_cur - LW'(1)));
    en        = !m.tvalid || m.tready;
    hs        = s.tvalid && s.tready;
    coef_eff  = s1_byp ? UNITY : CWE'(coef_rd);
    o_dat     = '0;
    for (int k = 0; k < CH; k++) begin
      prod[k] = PW'(s1_smp[k]) * PW'(coef_eff);
      rnd[k]  = (s2_prod[k] + RND) >>> FRAC;
      if (rnd[k] > SMAX)
        o_dat[k*DW +: DW] = SMAX[DW-1:0];
      else if (rnd[k] < SMIN)
        o_dat[k*DW +: DW] = SMIN[DW-1:0];
      else
        o_dat[k*DW +: DW] = rnd[k][DW-1:0];
    end
  end

  assign s.tready = en && rdy_ok;

  always_ff @(posedge clk) begin
    if (coef_we)
      coef_mem[coef_addr] <= coef_wdata;
  end

  // Read register sits in the RAM-style block so a same-cycle write still returns the old word.
  always_ff @(posedge clk) begin
    if (en)
      coef_rd <= coef_mem[idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_ok      <= 1'b0;
      idx         <= '0;
      len_q       <= LEN_MAX;
      byp_q       <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      rdy_ok <= 1'b1;
      if (hs) begin
        idx   <= (s.tlast || at_end) ? '0 : idx + 1'b1;
        len_q <= len_cur;
        byp_q <= byp_cur;
      end
      if (hs && s.tlast && !at_end)
        short_frame <= 1'b1;
      else if (short_clr)
        short_frame <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_byp   <= 1'b0;
      s2_vld   <= 1'b0;
      s2_last  <= 1'b0;
      m.tvalid <= 1'b0;
      m.tlast  <= 1'b0;
      m.tdata  <= '0;
      for (int k = 0; k < CH; k++) begin
        s1_smp[k]  <= '0;
        s2_prod[k] <= '0;
      end
    end else if (en) begin
      s1_vld   <= hs;
      s1_last  <= hs && (s.tlast || at_end);
      s1_byp   <= byp_cur;
      s2_vld   <= s1_vld;
      s2_last  <= s1_last;
      m.tvalid <= s2_vld;
      m.tlast  <= s2_last;
      m.tdata  <= o_dat;
      for (int k = 0; k < CH; k++) begin
        s1_smp[k]  <= s.tdata[k*DW +: DW];
        s2_prod[k] <= prod[k];
      end
    end
  end
endmodule

// File: tb/tb_fft_window_mc.sv
// Randomized scoreboard bench for fft_window_mc: a frame-level reference model queues expected beats,
// a negedge monitor pops and compares them and also checks hold stability, tready_s and short_frame.
module tb_fft_window_mc;
  localparam int DW = 16, CW = 16, FRAC = 15, CH = 2, N_LOG2 = 10;
  localparam int W = CH * DW;
  localparam int DEPTH = 1 << N_LOG2;

  typedef struct {
    logic [W-1:0] dat;
    logic         last;
    int           cyc;
    bit           lat_chk;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N_LOG2:0]   cfg_len;
  logic              cfg_bypass;
  logic              coef_we;
  logic [N_LOG2-1:0] coef_addr;
  logic [CW-1:0]     coef_wdata;
  logic              short_frame;
  logic              short_clr;

  fft_window_mc_if #(.W(W)) ifs ();
  fft_window_mc_if #(.W(W)) ifm ();

  fft_window_mc #(.DW(DW), .CW(CW), .FRAC(FRAC), .CH(CH), .N_LOG2(N_LOG2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s          (ifs),
    .m          (ifm),
    .cfg_len    (cfg_len),
    .cfg_bypass (cfg_bypass),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .short_frame(short_frame),
    .short_clr  (short_clr)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   bp_mode = 0;
  exp_t exp_q[$];
  int   model_coef [DEPTH];
  int   m_idx = 0, m_len = DEPTH;
  bit   m_byp = 0, m_short = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Exact rational rule: round(x*c / 2^FRAC) with ties toward +inf, then clamp to DW bits.
  function automatic logic [DW-1:0] win(input logic signed [DW-1:0] x, input int c);
    longint p, r;
    p = longint'(x) * longint'(c);
    r = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
    if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
    if (r < -(longint'(1) << (DW - 1)))    r = -(longint'(1) << (DW - 1));
    return r[DW-1:0];
  endfunction

  function automatic bit model_in(input logic [W-1:0] d, input logic last);
    exp_t e;
    int   c;
    bit   end_pos, short_set;
    if (m_idx == 0) begin
      m_len = (cfg_len == 0) ? DEPTH : int'(cfg_len);
      m_byp = cfg_bypass;
    end
    c = m_byp ? (1 << FRAC) : model_coef[m_idx];
    for (int k = 0; k < CH; k++) e.dat[k*DW +: DW] = win(d[k*DW +: DW], c);
    end_pos   = (m_idx == m_len - 1);
    e.last    = last || end_pos;
    e.cyc     = cyc;
    e.lat_chk = !bp_mode;
    exp_q.push_back(e);
    short_set = last && !end_pos;
    m_idx     = (last || end_pos) ? 0 : m_idx + 1;
    return short_set;
  endfunction

  logic [W-1:0] held_dat;
  logic         held_last;
  bit           have_hold = 0;

  always @(negedge clk) begin
    exp_t e;
    bit   set_now;
    if (!reset_n) begin
      exp_q.delete();
      m_idx     = 0;
      m_short   = 0;
      have_hold = 0;
    end else begin
      check("short_frame", short_frame, m_short);
      if (have_hold)
        check("hold_stable", {ifm.tvalid, ifm.tlast, ifm.tdata}, {1'b1, held_last, held_dat});
      if (ifm.tvalid && !ifm.tready) begin
        check("tready_s_stall", ifs.tready, 1'b0);
        held_dat  = ifm.tdata;
        held_last = ifm.tlast;
        have_hold = 1;
      end else begin
        have_hold = 0;
      end
      if (ifm.tvalid && ifm.tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h, expected no beat", ifm.tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", ifm.tdata, e.dat);
          check("out_last", ifm.tlast, e.last);
          if (e.lat_chk) check("latency", cyc - e.cyc, 3);
        end
      end
      set_now = 0;
      if (ifs.tvalid && ifs.tready) set_now = model_in(ifs.tdata, ifs.tlast);
      if (coef_we) model_coef[coef_addr] = int'($signed(coef_wdata));
      if (set_now) m_short = 1;
      else if (short_clr) m_short = 0;
    end
  end

  initial begin
    ifm.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifm.tready = bp_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, output int stalls);
    bit acc;
    stalls = 0;
    ifs.tdata  = d;
    ifs.tlast  = last;
    ifs.tvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = ifs.tready;
      tick();
      if (!acc) stalls++;
    end while (!acc && stalls < 500);
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got no tready_s, expected acceptance within 500 cycles");
    end
    ifs.tvalid = 1'b0;
    ifs.tlast  = 1'b0;
  endtask

  task automatic wr_coef(input int a, input logic [CW-1:0] v);
    coef_we    = 1'b1;
    coef_addr  = a[N_LOG2-1:0];
    coef_wdata = v;
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
    repeat (2) tick();
  endtask

  function automatic logic [W-1:0] iq(input int i, input int q);
    logic [W-1:0] d;
    d[DW-1:0]    = i[DW-1:0];
    d[2*DW-1:DW] = q[DW-1:0];
    return d;
  endfunction

  initial begin
    int st, st_sum;
    reset_n    = 1'b0;
    ifs.tvalid = 1'b0;
    ifs.tlast  = 1'b0;
    ifs.tdata  = '0;
    cfg_len    = 8;
    cfg_bypass = 1'b0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    short_clr  = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", ifm.tvalid, 1'b0);
    check("rst_tlast", ifm.tlast, 1'b0);
    check("rst_tdata", ifm.tdata, '0);
    check("rst_short", short_frame, 1'b0);
    reset_n = 1'b1;
    tick();
    check("tready_after_rst", ifs.tready, 1'b1);

    for (int a = 0; a < DEPTH; a++) wr_coef(a, CW'($urandom_range(0, 65535)));

    // Bypass passthrough, back-to-back, full frame ending exactly at len-1.
    cfg_bypass = 1'b1;
    cfg_len    = 8;
    st_sum     = 0;
    for (int k = 0; k < 8; k++) begin
      send(iq(k, -k), k == 7, st);
      st_sum += st;
    end
    check("bypass_throughput_stalls", st_sum, 0);
    drain("drain_bypass");

    // Window rounding and saturation with single-beat frames on coefficient 0.
    cfg_bypass = 1'b0;
    cfg_len    = 1;
    wr_coef(0, 16'h4000);
    send(iq(3, -3), 1'b0, st);
    send(iq(-3, 3), 1'b0, st);
    wr_coef(0, 16'h7FFF);
    send(iq(32'h7FFF, -32768), 1'b0, st);
    wr_coef(0, 16'h8000);
    send(iq(-32768, 32'h7FFF), 1'b0, st);
    send(iq(-32768, -32768), 1'b0, st);
    drain("drain_window");

    // Length 4 without tlast_s; a mid-frame cfg_len change must not take effect.
    cfg_len = 4;
    for (int k = 0; k < 10; k++) begin
      send(W'($urandom), 1'b0, st);
      if (k == 0) cfg_len = 2;
      if (k == 2) cfg_len = 4;
    end
    send(W'($urandom), 1'b1, st);
    repeat (3) tick();
    short_clr = 1'b1;
    tick();
    short_clr = 1'b0;
    send(W'($urandom), 1'b0, st);
    short_clr = 1'b1;
    send(W'($urandom), 1'b1, st);
    short_clr = 1'b0;
    repeat (2) tick();
    short_clr = 1'b1;
    tick();
    short_clr = 1'b0;
    // cfg_len = 0 means full depth: a tlast after three beats is short.
    cfg_len = 0;
    for (int k = 0; k < 3; k++) send(W'($urandom), k == 2, st);
    drain("drain_length");
    short_clr = 1'b1;
    tick();
    short_clr = 1'b0;

    // Random backpressure over a 64-beat frame with random input gaps.
    cfg_len = 64;
    bp_mode = 1;
    for (int k = 0; k < 64; k++) begin
      send(W'($urandom), k == 63, st);
      if ($urandom_range(0, 3) == 0) tick();
    end
    bp_mode = 0;
    drain("drain_backpressure");

    // Reset in the middle of a 16-beat frame.
    cfg_len = 16;
    for (int k = 0; k < 5; k++) send(W'($urandom), 1'b0, st);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tvalid", ifm.tvalid, 1'b0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("tready_after_rst2", ifs.tready, 1'b1);
    send(iq(12345, -2222), 1'b0, st);
    send(W'($urandom), 1'b0, st);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
